// File: rtl/vga_timing_gen_if.sv
// Video bus between the timing generator and the drawing / objects-mux side.
// The generator (master) issues raster coordinates and drives the DAC side;
// the mux (slave) returns the colour for each coordinate after PIPE_DELAY.
interface vga_timing_gen_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic [7:0]  frameCount;
  logic [7:0]  redIn;
  logic [7:0]  greenIn;
  logic [7:0]  blueIn;
  logic        hSync;
  logic        vSync;
  logic        blankN;
  logic [7:0]  redOut;
  logic [7:0]  greenOut;
  logic [7:0]  blueOut;

  modport master (
    output pixelX, pixelY, startOfFrame, frameCount,
    output hSync, vSync, blankN, redOut, greenOut, blueOut,
    input  redIn, greenIn, blueIn
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, frameCount,
    input  hSync, vSync, blankN, redOut, greenOut, blueOut,
    output redIn, greenIn, blueIn
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator and video output stage.
// Horizontal and vertical region FSMs produce the coordinates; sync/blank are
// delayed by PIPE_DELAY stages plus one output register so they line up with
// the colour that comes back from the objects mux for the same coordinate.
// The first clock edge after reset release holds the counters at 0,0 so the
// startOfFrame pulse for the first frame is visible to game logic.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic             clk,
  input  logic             resetN,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // last count of each region
  localparam logic [10:0] H_ACT_END = 11'(H_VISIBLE - 1);
  localparam logic [10:0] H_FP_END  = 11'(H_VISIBLE + H_FRONT - 1);
  localparam logic [10:0] H_SY_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] H_BP_END  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END = 11'(V_VISIBLE - 1);
  localparam logic [10:0] V_FP_END  = 11'(V_VISIBLE + V_FRONT - 1);
  localparam logic [10:0] V_SY_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] V_BP_END  = 11'(V_TOTAL - 1);

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

  typedef struct packed {
    logic hSync;
    logic vSync;
    logic blankN;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hSync: 1'b1, vSync: 1'b1, blankN: 1'b0};

  h_state_t    r_hState, w_hStateNxt;
  v_state_t    r_vState, w_vStateNxt;
  logic [10:0] r_hCount, w_hCountNxt;
  logic [10:0] r_vCount, w_vCountNxt;
  logic [7:0]  r_frameCount;
  logic        r_started;
  logic        w_lineTick;
  logic        w_frameTick;
  sync_t       w_raw;
  sync_t       w_dly;
  sync_t       r_out;
  logic [7:0]  r_red, r_green, r_blue;

  // released-from-reset flag; gates the counters for one edge after release
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_started <= 1'b0;
    else         r_started <= 1'b1;
  end

  // horizontal region state and pixel counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hState <= HS_ACT;
      r_hCount <= '0;
    end else if (r_started) begin
      r_hState <= w_hStateNxt;
      r_hCount <= w_hCountNxt;
    end
  end

  // horizontal next state: leave a region on its last count, wrap after back porch
  always_comb begin
    w_hStateNxt = r_hState;
    w_hCountNxt = r_hCount + 11'd1;
    w_lineTick  = 1'b0;
    case (r_hState)
      HS_ACT:  if (r_hCount == H_ACT_END) w_hStateNxt = HS_FP;
      HS_FP:   if (r_hCount == H_FP_END)  w_hStateNxt = HS_SYNC;
      HS_SYNC: if (r_hCount == H_SY_END)  w_hStateNxt = HS_BP;
      HS_BP: begin
        if (r_hCount == H_BP_END) begin
          w_hStateNxt = HS_ACT;
          w_hCountNxt = '0;
          w_lineTick  = 1'b1;
        end
      end
      default: w_hStateNxt = HS_ACT;
    endcase
  end

  // vertical region state and line counter, stepped by line ticks
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_vState <= VS_ACT;
      r_vCount <= '0;
    end else if (r_started) begin
      r_vState <= w_vStateNxt;
      r_vCount <= w_vCountNxt;
    end
  end

  // vertical next state: same region structure, advancing only on a line tick
  always_comb begin
    w_vStateNxt = r_vState;
    w_vCountNxt = r_vCount;
    w_frameTick = 1'b0;
    if (w_lineTick) begin
      w_vCountNxt = r_vCount + 11'd1;
      case (r_vState)
        VS_ACT:  if (r_vCount == V_ACT_END) w_vStateNxt = VS_FP;
        VS_FP:   if (r_vCount == V_FP_END)  w_vStateNxt = VS_SYNC;
        VS_SYNC: if (r_vCount == V_SY_END)  w_vStateNxt = VS_BP;
        VS_BP: begin
          if (r_vCount == V_BP_END) begin
            w_vStateNxt = VS_ACT;
            w_vCountNxt = '0;
            w_frameTick = 1'b1;
          end
        end
        default: w_vStateNxt = VS_ACT;
      endcase
    end
  end

  // completed-frame counter, modulo 256
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                       r_frameCount <= '0;
    else if (r_started && w_frameTick) r_frameCount <= r_frameCount + 8'd1;
  end

  // undelayed sync/blank for the current coordinate; idle until counting starts
  always_comb begin
    w_raw = SYNC_IDLE;
    if (r_started) begin
      w_raw.hSync  = (r_hState != HS_SYNC);
      w_raw.vSync  = (r_vState != VS_SYNC);
      w_raw.blankN = (r_hState == HS_ACT) && (r_vState == VS_ACT);
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign w_dly = w_raw;
    end else begin : g_pipe
      sync_t r_pipe [PIPE_DELAY];
      // shift sync/blank one stage per clock to match the colour latency
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int k = 0; k < PIPE_DELAY; k++) r_pipe[k] <= SYNC_IDLE;
        end else begin
          r_pipe[0] <= w_raw;
          for (int k = 1; k < PIPE_DELAY; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end
      assign w_dly = r_pipe[PIPE_DELAY-1];
    end
  endgenerate

  // output register: sync/blank with the colour, colour forced black when blanked
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_out   <= SYNC_IDLE;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_out   <= w_dly;
      r_red   <= w_dly.blankN ? vga.redIn   : 8'h00;
      r_green <= w_dly.blankN ? vga.greenIn : 8'h00;
      r_blue  <= w_dly.blankN ? vga.blueIn  : 8'h00;
    end
  end

  assign vga.pixelX       = r_hCount;
  assign vga.pixelY       = r_vCount;
  assign vga.startOfFrame = r_started && (r_hCount == '0) && (r_vCount == '0);
  assign vga.frameCount   = r_frameCount;
  assign vga.hSync        = r_out.hSync;
  assign vga.vSync        = r_out.vSync;
  assign vga.blankN       = r_out.blankN;
  assign vga.redOut       = r_red;
  assign vga.greenOut     = r_green;
  assign vga.blueOut      = r_blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing PIPE_DELAY=2,
// small timing PIPE_DELAY=2, small timing PIPE_DELAY=0) checked every cycle
// against a raster model computed from the pixel index since reset release.
module tb_vga_timing_gen;
  localparam int PD_A = 2;
  localparam int PD_B = 2;
  localparam int PD_C = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB, rstC;

  vga_timing_gen_if busA ();
  vga_timing_gen_if busB ();
  vga_timing_gen_if busC ();

  vga_timing_gen #(.PIPE_DELAY(PD_A)) dutA (.clk(clk), .resetN(rstA), .vga(busA));

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(PD_B)
  ) dutB (.clk(clk), .resetN(rstB), .vga(busB));

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(PD_C)
  ) dutC (.clk(clk), .resetN(rstC), .vga(busC));

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic [7:0]  fc;
    logic        hs;
    logic        vs;
    logic        bn;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } obs_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected observation in the cycle where pixel p is on pixelX/pixelY
  // (p<0: reset or the cycle before the first counting edge). The DAC side
  // shows pixel p-pd-1. Red is fed back as the column, green/blue constant.
  function automatic obs_t model(input int hv, hf, hsw, hb, vv, vf, vsw, vb, pd, p);
    obs_t e;
    int ht, vt, q, qx, qy;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (p >= 0) begin
      e.x   = 11'(p % ht);
      e.y   = 11'((p / ht) % vt);
      e.fc  = 8'((p / (ht * vt)) % 256);
      e.sof = (p % (ht * vt)) == 0;
    end
    q = p - pd - 1;
    if (q >= 0) begin
      qx = q % ht;
      qy = (q / ht) % vt;
      e.hs = !(qx >= hv + hf && qx < hv + hf + hsw);
      e.vs = !(qy >= vv + vf && qy < vv + vf + vsw);
      e.bn = (qx < hv) && (qy < vv);
      if (e.bn) begin
        e.r = 8'(qx);
        e.g = 8'hFF;
        e.b = 8'h5A;
      end
    end
    return e;
  endfunction

  // colour the mux returns during cycle p: column of pixel p-pd
  function automatic logic [7:0] red_for(input int p, pd, ht);
    return (p - pd >= 0) ? 8'((p - pd) % ht) : 8'h00;
  endfunction

  task automatic check_obs(input string t, input obs_t a, input obs_t e);
    chk({t, ".pixelX"},       32'(a.x),   32'(e.x));
    chk({t, ".pixelY"},       32'(a.y),   32'(e.y));
    chk({t, ".startOfFrame"}, 32'(a.sof), 32'(e.sof));
    chk({t, ".frameCount"},   32'(a.fc),  32'(e.fc));
    chk({t, ".hSync"},        32'(a.hs),  32'(e.hs));
    chk({t, ".vSync"},        32'(a.vs),  32'(e.vs));
    chk({t, ".blankN"},       32'(a.bn),  32'(e.bn));
    chk({t, ".redOut"},       32'(a.r),   32'(e.r));
    chk({t, ".greenOut"},     32'(a.g),   32'(e.g));
    chk({t, ".blueOut"},      32'(a.b),   32'(e.b));
  endtask

  int   kA = -1, kB = -1, kC = -1;
  int   pA, pB, pC;
  obs_t oA, oB, oC;
  bit   aFirst = 1'b1;
  int   aHsLow = 0, aHsFirst = -1, aBnHigh = 0, aBnFirst = -1;
  int   bVsLow = 0, bLastSof = -1, bNSof = 0;

  // per-cycle compare against the model, then drive the returned colour
  always @(negedge clk) begin
    kA = rstA ? kA + 1 : -1;
    kB = rstB ? kB + 1 : -1;
    kC = rstC ? kC + 1 : -1;
    pA = kA - 1;
    pB = kB - 1;
    pC = kC - 1;

    oA = {busA.pixelX, busA.pixelY, busA.startOfFrame, busA.frameCount, busA.hSync,
          busA.vSync, busA.blankN, busA.redOut, busA.greenOut, busA.blueOut};
    oB = {busB.pixelX, busB.pixelY, busB.startOfFrame, busB.frameCount, busB.hSync,
          busB.vSync, busB.blankN, busB.redOut, busB.greenOut, busB.blueOut};
    oC = {busC.pixelX, busC.pixelY, busC.startOfFrame, busC.frameCount, busC.hSync,
          busC.vSync, busC.blankN, busC.redOut, busC.greenOut, busC.blueOut};
    check_obs("A", oA, model(640, 16, 96, 48, 480, 10, 2, 33, PD_A, pA));
    check_obs("B", oB, model(4, 1, 2, 1, 3, 1, 1, 1, PD_B, pB));
    check_obs("C", oC, model(4, 1, 2, 1, 3, 1, 1, 1, PD_C, pC));

    // literal anchors for the start of counting and the line wrap
    if (aFirst && pA == 0) chk("A.sofFirst", 32'(busA.startOfFrame), 1);
    if (aFirst && pA == 1) chk("A.sofSecond", 32'(busA.startOfFrame), 0);
    if (aFirst && pA == 2) chk("A.x2", 32'(busA.pixelX), 2);
    if (aFirst && pA == 799) chk("A.x799", 32'(busA.pixelX), 799);
    if (aFirst && pA == 800) chk("A.xWrap", 32'(busA.pixelX), 0);

    // first output line of A: sync/blank run lengths and positions
    if (aFirst && pA >= 0 && pA <= PD_A + 800) begin
      if (!busA.hSync) begin
        aHsLow++;
        if (aHsFirst < 0) aHsFirst = pA;
      end
      if (busA.blankN) begin
        aBnHigh++;
        if (aBnFirst < 0) aBnFirst = pA;
      end
    end

    // small timing: vSync width, frame period, frame counter sequence and wrap
    if (pB >= PD_B + 1 && pB <= PD_B + 48 && !busB.vSync) bVsLow++;
    if (rstB && busB.startOfFrame) begin
      if (bLastSof >= 0) chk("B.sofPeriod", 32'(pB - bLastSof), 48);
      if (bNSof inside {0, 1, 2, 3, 255, 256})
        chk($sformatf("B.frameAtSof%0d", bNSof), 32'(busB.frameCount), 32'(bNSof % 256));
      bLastSof = pB;
      bNSof++;
    end

    busA.redIn = red_for(pA, PD_A, 800);
    busB.redIn = red_for(pB, PD_B, 8);
    busC.redIn = red_for(pC, PD_C, 8);
    busA.greenIn = 8'hFF; busB.greenIn = 8'hFF; busC.greenIn = 8'hFF;
    busA.blueIn  = 8'h5A; busB.blueIn  = 8'h5A; busC.blueIn  = 8'h5A;
  end

  initial begin
    rstA = 1'b0;
    rstB = 1'b0;
    rstC = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("A.heldPixelX", 32'(busA.pixelX), 0);
    chk("A.heldHSync", 32'(busA.hSync), 1);
    chk("A.heldSof", 32'(busA.startOfFrame), 0);
    #1;
    rstA = 1'b1;
    rstB = 1'b1;
    rstC = 1'b1;

    // run A to hCount=300, vCount=2, then reset it mid-line
    repeat (1901) @(posedge clk);
    #2;
    chk("A.preRstX", 32'(busA.pixelX), 300);
    chk("A.preRstY", 32'(busA.pixelY), 2);
    chk("A.preRstBlankN", 32'(busA.blankN), 1);
    #1;
    rstA = 1'b0;
    aFirst = 1'b0;
    #1;
    chk("A.rstPixelX", 32'(busA.pixelX), 0);
    chk("A.rstPixelY", 32'(busA.pixelY), 0);
    chk("A.rstFrame", 32'(busA.frameCount), 0);
    chk("A.rstHSync", 32'(busA.hSync), 1);
    chk("A.rstVSync", 32'(busA.vSync), 1);
    chk("A.rstBlankN", 32'(busA.blankN), 0);
    chk("A.rstRed", 32'(busA.redOut), 0);
    repeat (3) @(posedge clk);
    #3;
    rstA = 1'b1;

    repeat (12400) @(posedge clk);
    #2;
    chk("A.hsLowCycles", 32'(aHsLow), 96);
    chk("A.hsFirstLow", 32'(aHsFirst), 656 + PD_A + 1);
    chk("A.bnHighCycles", 32'(aBnHigh), 640);
    chk("A.bnFirstHigh", 32'(aBnFirst), PD_A + 1);
    chk("B.vsLowCycles", 32'(bVsLow), 8);
    chk("B.enoughFrames", 32'(bNSof >= 257), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
